lsu: RTL

Load/store unit for the RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address, then runs one data-memory transaction over a request/response handshake. For loads it returns the byte/halfword/word aligned and sign- or zero-extended; for stores it generates byte enables and lane-replicated write data. It flags misaligned and illegal-width accesses without touching memory.

---
 rtl/lsu.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction per start, with load
// extraction/extension, store lane replication and early fault detection.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic        mis_q, ill_q, mis_d, ill_d;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [3:0]  be;
  logic [31:0] wd;

  // Fault decode on the live inputs; illegal width masks misalignment.
  always_comb begin
    ill_d = 1'b0;
    mis_d = 1'b0;
    case (funct3)
      3'b000:         mis_d = 1'b0;
      3'b001:         mis_d = addr[0];
      3'b010:         mis_d = |addr[1:0];
      3'b100, 3'b101: begin
        ill_d = is_store;
        mis_d = funct3[0] & addr[0];
      end
      default:        ill_d = 1'b1;
    endcase
    if (ill_d) mis_d = 1'b0;
  end

  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (f3_q[1:0])
      2'b00: begin be = 4'b0001 << addr_q[1:0]; wd = {4{wdata_q[7:0]}};  end
      2'b01: begin be = 4'b0011 << addr_q[1:0]; wd = {2{wdata_q[15:0]}}; end
      default: ;
    endcase
  end

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (ill_d | mis_d) ? S_FAULT : S_REQ;
      S_REQ:   if (mem_ready) state_d = st_q ? S_DONE : S_WAIT;
      S_WAIT:  if (mem_rvalid) begin
        state_d = S_DONE;
        rdata_d = ext;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (state_q == S_IDLE && start) begin
        st_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        mis_q   <= mis_d;
        ill_q   <= ill_d;
      end
    end
  end

  // Memory outputs are zero outside REQ so nothing leaks from stale captures.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) || (state_q == S_FAULT);
  assign misaligned = (state_q == S_FAULT) & mis_q;
  assign illegal    = (state_q == S_FAULT) & ill_q;
  assign rdata      = rdata_q;
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req & st_q;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be     = mem_req ? be : 4'd0;
  assign mem_wdata  = mem_req ? wd : 32'd0;
endmodule
